immediate_packer: RTL
=====================

// Module: immediate_packer
// PURPOSE
//  Inverse of immediate_extender: packs a 32-bit immediate value and a format code into the
//  20-bit compact immediate field consumed by the extender. Also flags values not representable.
//  Streaming valid/ready block with a 2-entry pipeline, used by the instruction assembler/loader
//  ahead of instruction memory writes. Holds running word and error counters.
//  Invariant: immediate_extender(imm_out, ctl_out) == value_in for every beat with err_out == 0.
// PARAMETERS
//  CNT_W   16  width of beat counter out_count
//  ERR_W   8   width of saturating error counter err_count
// PORTS
//  clk        input   1      clock, all state updates on rising edge
//  rst        input   1      reset, synchronous, active-low
//  in_valid   input   1      input beat valid
//  in_ready   output  1      block accepts a beat this cycle
//  value_in   input   32     immediate value to pack
//  ctl_in     input   2      format: 0=I, 1=B, 2=U (20-bit), 3=J
//  out_valid  output  1      output beat valid
//  out_ready  input   1      downstream accepts the beat
//  imm_out    output  20     packed compact immediate
//  ctl_out    output  2      format, passed through with its beat
//  err_out    output  1      value not representable in the format
//  out_count  output  CNT_W  number of beats delivered (wraps)
//  err_count  output  ERR_W  number of delivered beats with err_out=1 (saturates at all-ones)
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): both stages empty, out_valid=0, imm_out=0, ctl_out=0,
//    err_out=0, out_count=0, err_count=0. in_ready=0 while rst==0. Reset discards in-flight beats.
//  - Handshake: transfer occurs when valid&&ready at an edge. out_valid, imm_out, ctl_out and
//    err_out are held stable until the transfer; in_valid never depends on in_ready.
//  - Pipeline: stage S1 registers value_in/ctl_in and computes the packing. Stage S2 is the output
//    register. A beat accepted at edge N is presented at edge N+2 when no stall occurs (latency 2).
//  - Throughput: one beat per cycle. in_ready = !S1_full || (S1 can move to S2 this cycle).
//    S2 loads when empty or on an output transfer. Simultaneous accept and output transfer is
//    legal: no bubble, no loss, no duplication. Order is preserved.
//  - Packing (v = value_in; upper field bits are zero-filled):
//      I: imm={8'b0,v[11:0]}  ok iff v[31:11] all equal
//      B: imm={8'b0,v[12:1]}  ok iff v[31:12] all equal and v[0]==0
//      U: imm=v[19:0]         ok iff v[31:19] all equal
//      J: imm=v[20:1]         ok iff v[31:20] all equal and v[0]==0
//    On !ok, imm still carries the truncated bits shown above, and err=1.
//  - Counters update only on an output transfer. out_count increments and wraps.
//    err_count increments when err_out==1 and holds at all-ones.
// CONFIGURATION
//  IMM_RANGE_CHECK_EN defined: range/alignment checks as above; err_out and err_count active.
//  IMM_RANGE_CHECK_EN undefined: no check logic; err_out tied 0; err_count tied 0; packing unchanged.
// TESTING
//  1. I, value_in=32'hFFFF_F90A, out_ready=1 -> 2 cycles later imm_out=20'h0090A, err_out=0, out_count=1.
//  2. B, 32'h0000_0014 -> imm_out=20'h0000A, err_out=0; B, 32'h0000_0015 -> err_out=1, err_count=1.
//  3. U, 32'hFFFA_000A -> imm_out=20'hA000A; J, 32'hFFF4_0014 -> imm_out=20'hA000A; both err_out=0.
//  4. I, 32'h0000_0800 -> imm_out=20'h00800, err_out=1. Feed through immediate_extender for
//     random in-range beats -> extender output equals value_in on every beat.
//  5. 4 back-to-back beats, out_ready=0 for 3 cycles -> in_ready drops after 2 beats are held.
//     All 4 beats then emerge in order, no loss or duplication, out_count=4.
//  6. rst=0 with 2 beats in flight -> next cycle out_valid=0, out_count=0, err_count=0, in_ready=0.
//     After release, a new beat passes with latency 2.

Source files
------------

// File: rtl/immediate_packer.sv
// immediate_packer: packs a 32-bit immediate plus a format code into the 20-bit
// compact immediate field read by immediate_extender. Two-stage valid/ready pipeline
// (S1 input register, S2 output register) with beat and error counters.
// Optional build macro: IMM_RANGE_CHECK_EN enables the range/alignment checks that
// drive err_out and err_count; without it both are tied to zero and packing is unchanged.
module immediate_packer #(
   parameter int CNT_W = 16,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      value_in,
   input  logic [1:0]       ctl_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [19:0]      imm_out,
   output logic [1:0]       ctl_out,
   output logic             err_out,
   output logic [CNT_W-1:0] out_count,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {
      FMT_I = 2'd0,
      FMT_B = 2'd1,
      FMT_U = 2'd2,
      FMT_J = 2'd3
   } fmt_t;

   logic        s1_full;
   logic [31:0] s1_value;
   logic [1:0]  s1_ctl;
   logic        s2_full;
   logic [19:0] pack_imm;
   logic        out_fire;
   logic        s2_load;
   logic        s1_move;
   logic        in_accept;

   // S2 can take a new beat when it is empty or its current beat leaves this cycle;
   // S1 can then always accept, which gives full throughput without a bubble.
   assign out_valid = s2_full;
   assign out_fire  = s2_full && out_ready;
   assign s2_load   = !s2_full || out_ready;
   assign s1_move   = s1_full && s2_load;
   assign in_ready  = rst && (!s1_full || s2_load);
   assign in_accept = in_valid && in_ready;

   // Compact field extraction from the S1 value; upper unused bits are zero-filled
   always_comb begin
      pack_imm = '0;
      case (fmt_t'(s1_ctl))
         FMT_I:   pack_imm = {8'b0, s1_value[11:0]};
         FMT_B:   pack_imm = {8'b0, s1_value[12:1]};
         FMT_U:   pack_imm = s1_value[19:0];
         FMT_J:   pack_imm = s1_value[20:1];
         default: pack_imm = '0;
      endcase
   end

   // S1: capture the incoming beat, or empty out when the beat moves on to S2
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_full  <= 1'b0;
         s1_value <= '0;
         s1_ctl   <= '0;
      end else if (in_accept) begin
         s1_full  <= 1'b1;
         s1_value <= value_in;
         s1_ctl   <= ctl_in;
      end else if (s1_move) begin
         s1_full  <= 1'b0;
      end
   end

   // S2: output register, held stable until the downstream transfer
   always_ff @(posedge clk) begin
      if (!rst) begin
         s2_full <= 1'b0;
         imm_out <= '0;
         ctl_out <= '0;
      end else if (s2_load) begin
         s2_full <= s1_full;
         if (s1_full) begin
            imm_out <= pack_imm;
            ctl_out <= s1_ctl;
         end
      end
   end

   // Beat counter, wraps naturally at CNT_W bits
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_count <= '0;
      end else if (out_fire) begin
         out_count <= out_count + 1'b1;
      end
   end

`ifdef IMM_RANGE_CHECK_EN
   logic pack_ok;

   // Representable when all bits above the field's sign bit match it, and
   // the dropped bit 0 is zero for the halfword-aligned B and J formats
   always_comb begin
      pack_ok = 1'b1;
      case (fmt_t'(s1_ctl))
         FMT_I:   pack_ok = (&s1_value[31:11]) || !(|s1_value[31:11]);
         FMT_B:   pack_ok = ((&s1_value[31:12]) || !(|s1_value[31:12])) && !s1_value[0];
         FMT_U:   pack_ok = (&s1_value[31:19]) || !(|s1_value[31:19]);
         FMT_J:   pack_ok = ((&s1_value[31:20]) || !(|s1_value[31:20])) && !s1_value[0];
         default: pack_ok = 1'b1;
      endcase
   end

   // Error flag travels with its beat into S2
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_out <= 1'b0;
      end else if (s2_load && s1_full) begin
         err_out <= !pack_ok;
      end
   end

   // Error counter, sticks at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_count <= '0;
      end else if (out_fire && err_out && !(&err_count)) begin
         err_count <= err_count + 1'b1;
      end
   end
`else
   logic unused_value_bits;

   assign unused_value_bits = ^s1_value[31:21];
   assign err_out           = 1'b0;
   assign err_count         = '0;
`endif

endmodule
